// File: rtl/register_file.sv
// MIPS-32 register-read stage: 32x32 regfile, two async read ports, RegDst/MemtoReg/ALUSrc muxes; optional REGFILE_BYPASS_EN forwarding.
// Latency: reads and muxes are combinational, writes land on falling CLK; no backpressure.
module register_file (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic [31:0] Instr,
   input  logic [31:0] Immediate,
   input  logic [31:0] Result,
   input  logic [31:0] memData,
   input  logic        RegDst,
   input  logic        RegWrite,
   input  logic        ALUSrc,
   input  logic        MemtoReg,
   output logic [31:0] Read1,
   output logic [31:0] Read2,
   output logic [31:0] ALUin,
   output logic [4:0]  WriteReg,
   output logic [31:0] Writedata
);

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] regs [31:1];
   logic [31:0] arr1;
   logic [31:0] arr2;

   assign rs = Instr[25:21];
   assign rt = Instr[20:16];
   assign rd = Instr[15:11];

   assign WriteReg  = RegDst ? rd : rt;
   assign Writedata = MemtoReg ? memData : Result;

   // Register 0 has no storage, so writes addressed to it simply match no entry.
   always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (RegWrite) begin
         for (int i = 1; i < 32; i++) begin
            if (WriteReg == 5'(i)) begin
               regs[i] <= Writedata;
            end
         end
      end
   end

   always_comb begin
      arr1 = '0;
      arr2 = '0;
      for (int i = 1; i < 32; i++) begin
         if (rs == 5'(i)) arr1 = regs[i];
         if (rt == 5'(i)) arr2 = regs[i];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_ok;

   // Forward the pending write so a reader sees it before the falling edge.
   assign fwd_ok = RegWrite && Reset_L && (WriteReg != 5'd0);
   assign Read1  = (fwd_ok && (rs == WriteReg)) ? Writedata : arr1;
   assign Read2  = (fwd_ok && (rt == WriteReg)) ? Writedata : arr2;
`else
   assign Read1 = arr1;
   assign Read2 = arr2;
`endif

   assign ALUin = ALUSrc ? Immediate : Read2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: writes on falling edges, checks taken 1ns after edges.
module tb_register_file;

   logic        CLK;
   logic        Reset_L;
   logic [31:0] Instr;
   logic [31:0] Immediate;
   logic [31:0] Result;
   logic [31:0] memData;
   logic        RegDst;
   logic        RegWrite;
   logic        ALUSrc;
   logic        MemtoReg;
   logic [31:0] Read1;
   logic [31:0] Read2;
   logic [31:0] ALUin;
   logic [4:0]  WriteReg;
   logic [31:0] Writedata;

   int checks = 0;
   int errors = 0;

   register_file dut (
      .CLK(CLK), .Reset_L(Reset_L), .Instr(Instr), .Immediate(Immediate),
      .Result(Result), .memData(memData), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .Read1(Read1), .Read2(Read2),
      .ALUin(ALUin), .WriteReg(WriteReg), .Writedata(Writedata)
   );

   initial CLK = 1'b1;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 11'd0};
   endfunction

   // R-type write of data into rd, launched after a rising edge and committed on the next falling edge.
   task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
      @(posedge CLK); #1;
      Instr = mk(5'd0, 5'd0, rd); RegDst = 1'b1; MemtoReg = 1'b0;
      Result = data; RegWrite = 1'b1;
      @(negedge CLK); #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_reset;
      Reset_L = 1'b0;
      Instr = mk(5'd5, 5'd6, 5'd7); RegDst = 1'b1; MemtoReg = 1'b1;
      memData = 32'hA5A5_0001; Result = 32'h0000_0002; ALUSrc = 1'b1; Immediate = 32'h0000_0BAD;
      #12;
      checks++; if (Read1 !== 32'h0) begin errors++; $display("FAIL reset_read1 got %h want %h", Read1, 32'h0); end
      checks++; if (Read2 !== 32'h0) begin errors++; $display("FAIL reset_read2 got %h want %h", Read2, 32'h0); end
      checks++; if (ALUin !== 32'h0000_0BAD) begin errors++; $display("FAIL reset_aluin_imm got %h want %h", ALUin, 32'h0000_0BAD); end
      checks++; if (WriteReg !== 5'd7) begin errors++; $display("FAIL reset_writereg got %0d want %0d", WriteReg, 7); end
      checks++; if (Writedata !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_writedata got %h want %h", Writedata, 32'hA5A5_0001); end
      ALUSrc = 1'b0; #1;
      checks++; if (ALUin !== 32'h0) begin errors++; $display("FAIL reset_aluin_reg got %h want %h", ALUin, 32'h0); end
      @(posedge CLK); #1;
      Reset_L = 1'b1;
      // Preload r5 then assert reset mid-cycle with no edge.
      do_write(5'd5, 32'hDEAD_BEEF);
      Instr = mk(5'd5, 5'd0, 5'd0); #1;
      checks++; if (Read1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL preload_r5 got %h want %h", Read1, 32'hDEAD_BEEF); end
      @(posedge CLK); #2;
      Reset_L = 1'b0; #1;
      checks++; if (Read1 !== 32'h0) begin errors++; $display("FAIL async_clear_r5 got %h want %h", Read1, 32'h0); end
      Reset_L = 1'b1;
   endtask

   task automatic test_reset_write_ignored;
      do_write(5'd4, 32'h0000_4444);
      @(posedge CLK); #1;
      Instr = mk(5'd4, 5'd0, 5'd4); RegDst = 1'b1; MemtoReg = 1'b0;
      Result = 32'h7777_7777; RegWrite = 1'b1;
      @(negedge CLK);
      Reset_L = 1'b0;
      #1;
      RegWrite = 1'b0;
      checks++; if (Read1 !== 32'h0) begin errors++; $display("FAIL reset_edge_write got %h want %h", Read1, 32'h0); end
      @(posedge CLK); #1;
      Reset_L = 1'b1; RegWrite = 1'b1; Result = 32'h0000_0042;
      @(negedge CLK); #1;
      RegWrite = 1'b0;
      checks++; if (Read1 !== 32'h0000_0042) begin errors++; $display("FAIL first_write_after_reset got %h want %h", Read1, 32'h0000_0042); end
   endtask

   task automatic test_rtype;
      @(posedge CLK); #1;
      Instr = mk(5'd0, 5'd1, 5'd9); RegDst = 1'b1; MemtoReg = 1'b0;
      Result = 32'h1234_5678; RegWrite = 1'b1; #1;
      checks++; if (WriteReg !== 5'd9) begin errors++; $display("FAIL rtype_writereg got %0d want %0d", WriteReg, 9); end
      @(negedge CLK); #1;
      RegWrite = 1'b0;
      Instr = mk(5'd9, 5'd9, 5'd9); #1;
      checks++; if (Read1 !== 32'h1234_5678) begin errors++; $display("FAIL rtype_read1 got %h want %h", Read1, 32'h1234_5678); end
      checks++; if (Read2 !== 32'h1234_5678) begin errors++; $display("FAIL same_addr_read2 got %h want %h", Read2, 32'h1234_5678); end
   endtask

   task automatic test_load;
      @(posedge CLK); #1;
      Instr = mk(5'd0, 5'd3, 5'd12); RegDst = 1'b0; MemtoReg = 1'b1;
      memData = 32'hCAFE_F00D; Result = 32'h0BAD_0BAD; RegWrite = 1'b1; #1;
      checks++; if (WriteReg !== 5'd3) begin errors++; $display("FAIL load_writereg got %0d want %0d", WriteReg, 3); end
      checks++; if (Writedata !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_writedata got %h want %h", Writedata, 32'hCAFE_F00D); end
      @(negedge CLK); #1;
      RegWrite = 1'b0;
      Instr = mk(5'd3, 5'd12, 5'd0); #1;
      checks++; if (Read1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_r3 got %h want %h", Read1, 32'hCAFE_F00D); end
      checks++; if (Read2 !== 32'h0) begin errors++; $display("FAIL load_r12_untouched got %h want %h", Read2, 32'h0); end
      @(posedge CLK); #1;
      Instr = mk(5'd3, 5'd3, 5'd0); RegDst = 1'b0; MemtoReg = 1'b1;
      memData = 32'h1111_1111; RegWrite = 1'b0;
      @(negedge CLK); #1;
      checks++; if (Read1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL regwrite0_hold got %h want %h", Read1, 32'hCAFE_F00D); end
   endtask

   task automatic test_zero_reg;
      do_write(5'd0, 32'hFFFF_FFFF);
      Instr = mk(5'd0, 5'd0, 5'd0); #1;
      checks++; if (Read1 !== 32'h0) begin errors++; $display("FAIL zero_read1 got %h want %h", Read1, 32'h0); end
      checks++; if (Read2 !== 32'h0) begin errors++; $display("FAIL zero_read2 got %h want %h", Read2, 32'h0); end
   endtask

   task automatic test_alusrc;
      do_write(5'd2, 32'h0000_0010);
      Instr = mk(5'd0, 5'd2, 5'd0); Immediate = 32'hFFFF_FFFC; ALUSrc = 1'b0; #1;
      checks++; if (ALUin !== 32'h0000_0010) begin errors++; $display("FAIL alusrc0 got %h want %h", ALUin, 32'h0000_0010); end
      ALUSrc = 1'b1; #1;
      checks++; if (ALUin !== 32'hFFFF_FFFC) begin errors++; $display("FAIL alusrc1 got %h want %h", ALUin, 32'hFFFF_FFFC); end
      ALUSrc = 1'b0;
   endtask

   task automatic test_back_to_back;
      do_write(5'd10, 32'h0A0A_0A0A);
      do_write(5'd11, 32'h0B0B_0B0B);
      do_write(5'd31, 32'h8000_0001);
      Instr = mk(5'd10, 5'd11, 5'd0); #1;
      checks++; if (Read1 !== 32'h0A0A_0A0A) begin errors++; $display("FAIL b2b_r10 got %h want %h", Read1, 32'h0A0A_0A0A); end
      checks++; if (Read2 !== 32'h0B0B_0B0B) begin errors++; $display("FAIL b2b_r11 got %h want %h", Read2, 32'h0B0B_0B0B); end
      Instr = mk(5'd31, 5'd10, 5'd0); #1;
      checks++; if (Read1 !== 32'h8000_0001) begin errors++; $display("FAIL b2b_r31 got %h want %h", Read1, 32'h8000_0001); end
   endtask

   task automatic test_bypass;
      logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
      exp_pre = 32'h0000_0055;
`else
      exp_pre = 32'h0000_0000;
`endif
      @(posedge CLK); #1;
      Instr = mk(5'd7, 5'd0, 5'd7); RegDst = 1'b1; MemtoReg = 1'b0;
      Result = 32'h0000_0055; RegWrite = 1'b1; #1;
      checks++; if (Read1 !== exp_pre) begin errors++; $display("FAIL bypass_pre_edge got %h want %h", Read1, exp_pre); end
      @(negedge CLK); #1;
      RegWrite = 1'b0; #1;
      checks++; if (Read1 !== 32'h0000_0055) begin errors++; $display("FAIL bypass_post_edge got %h want %h", Read1, 32'h0000_0055); end
   endtask

   initial begin
      Reset_L = 1'b0; Instr = '0; Immediate = '0; Result = '0; memData = '0;
      RegDst = 1'b0; RegWrite = 1'b0; ALUSrc = 1'b0; MemtoReg = 1'b0;
      test_reset;
      test_reset_write_ignored;
      test_rtype;
      test_load;
      test_zero_reg;
      test_alusrc;
      test_back_to_back;
      test_bypass;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
